// File: rtl/trace_serializer.sv
// ============================================================================
// Module   : trace_serializer
// Purpose  : Replays trace-memory words as 2**n-bit parallel beats, LSB-first,
//            over a valid/ready handshake with one prefetch word buffered.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_serializer #(
    parameter int TRB_WIDTH       = 64,
    parameter int TRB_MAX_TRACES  = 8,
    parameter int TRB_NTRACE_BITS = 2
) (
    input  logic                       CLK_I,
    input  logic                       RST_I,
    input  logic [TRB_NTRACE_BITS-1:0] EXP_TRACES_I,
    input  logic [TRB_WIDTH-1:0]       DATA_I,
    input  logic                       LOAD_PERM_I,
    output logic                       LOAD_O,
    output logic [TRB_MAX_TRACES-1:0]  TRACE_O,
    output logic                       TRACE_VALID_O,
    input  logic                       TRACE_READY_I
);

    localparam int POS_W   = $clog2(TRB_WIDTH);
    localparam int MAX_EXP = $clog2(TRB_MAX_TRACES);

    logic [TRB_WIDTH-1:0]       r_word;
    logic                       r_word_valid;
    logic [POS_W-1:0]           r_pos;
    logic [TRB_NTRACE_BITS-1:0] r_exp;
    logic [TRB_WIDTH-1:0]       r_buf;
    logic                       r_buf_valid;

    logic [TRB_NTRACE_BITS-1:0] w_exp_clamped;
    logic [POS_W:0]             w_n;
    logic [POS_W:0]             w_pos_next;
    logic                       w_xfer;
    logic                       w_last_xfer;
    logic                       w_promote;
    logic                       w_load;
    logic [TRB_WIDTH-1:0]       w_shifted;
    logic [TRB_MAX_TRACES-1:0]  w_trace;

    always_comb begin
        w_exp_clamped = EXP_TRACES_I;
        if ({{(32-TRB_NTRACE_BITS){1'b0}}, EXP_TRACES_I} > 32'(MAX_EXP))
            w_exp_clamped = TRB_NTRACE_BITS'(MAX_EXP);
    end

    assign w_n         = (POS_W+1)'(1) << r_exp;
    assign w_pos_next  = {1'b0, r_pos} + w_n;
    assign w_xfer      = r_word_valid & TRACE_READY_I;
    assign w_last_xfer = w_xfer & (w_pos_next == (POS_W+1)'(TRB_WIDTH));

    // The prefetch word moves up when nothing is active or the active word retires now
    assign w_promote = r_buf_valid & (~r_word_valid | w_last_xfer);
    assign w_load    = LOAD_PERM_I & (~r_buf_valid | w_promote) & ~RST_I;
    assign LOAD_O    = w_load;

    // Beat lanes beyond the active width read as zero
    assign w_shifted = r_word >> r_pos;
    always_comb begin
        w_trace = '0;
        for (int i = 0; i < TRB_MAX_TRACES; i++) begin
            if ((POS_W+1)'(i) < w_n)
                w_trace[i] = w_shifted[i];
        end
    end

    assign TRACE_O       = w_trace;
    assign TRACE_VALID_O = r_word_valid;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
        end else if (w_load) begin
            r_buf       <= DATA_I;
            r_buf_valid <= 1'b1;
        end else if (w_promote) begin
            r_buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_pos        <= '0;
            r_exp        <= '0;
        end else if (w_promote) begin
            r_word       <= r_buf;
            r_word_valid <= 1'b1;
            r_pos        <= '0;
            r_exp        <= w_exp_clamped;
        end else if (w_last_xfer) begin
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_pos        <= '0;
        end else if (w_xfer) begin
            r_pos        <= w_pos_next[POS_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: doc/trace_serializer.md
Name: trace_serializer

Overview:
- Replay-side counterpart of the trace capture path.
- Fetches TRB_WIDTH-bit words from trace memory and emits them as 2**EXP_TRACES_I parallel trace bits per beat, LSB-first, over a valid/ready handshake.
- Used for trace replay and stimulus injection into the DUT.
- Double-buffered (active word plus one prefetch word) so consecutive words stream without a gap.

Parameters:
TRB_WIDTH, 64, memory word width in bits; power of 2, multiple of TRB_MAX_TRACES.
TRB_MAX_TRACES, 8, maximum number of parallel trace lines; power of 2.
TRB_NTRACE_BITS, 2, width of the trace-count exponent.

Ports:
CLK_I  in  1  clock.
RST_I  in  1  reset; asynchronous, active-high.
EXP_TRACES_I  in  TRB_NTRACE_BITS  exponent n; beat width = 2**n, clamped to TRB_MAX_TRACES.
DATA_I  in  TRB_WIDTH  memory read word; valid while LOAD_PERM_I=1.
LOAD_PERM_I  in  1  memory has a word available.
LOAD_O  out  1  word accepted this cycle; memory advances its read pointer.
TRACE_O  out  TRB_MAX_TRACES  current trace beat.
TRACE_VALID_O  out  1  TRACE_O holds valid data.
TRACE_READY_I  in  1  consumer accepts the beat.

Behaviour:
- State:
  - word_reg, word_valid, pos (log2(TRB_WIDTH) bits), exp_q (active word).
  - buf_reg, buf_valid (prefetch).
- Reset (async, RST_I=1):
  - All state cleared immediately.
  - TRACE_VALID_O=0, TRACE_O=0, LOAD_O=0 (forced low while RST_I=1).
- Load handshake:
  - LOAD_O = LOAD_PERM_I & (~buf_valid | buf_consumed), where buf_consumed means buf moves to word_reg this cycle.
  - Combinational output.
  - On the edge where LOAD_O=1: buf_reg<=DATA_I, buf_valid<=1.
  - LOAD_O is never high for two words without a buffer slot free.
- Promotion (buf to word): occurs when buf_valid=1 and either:
  - word_valid=0, or
  - the last beat of word_reg transfers this cycle.
  - On promotion: word_reg<=buf_reg, word_valid<=1, pos<=0, exp_q<=clamp(EXP_TRACES_I).
- Beat width:
  - N = 2**exp_q.
  - EXP_TRACES_I is sampled only at promotion; changes mid-word are ignored.
- Output:
  - TRACE_O[i] = word_reg[pos+i] for i<N; bits i>=N are 0.
  - TRACE_VALID_O = word_valid.
  - Both are driven from registers only; there is no combinational path from TRACE_READY_I.
- Transfer:
  - A transfer occurs when TRACE_VALID_O & TRACE_READY_I. It then sets pos<=pos+N.
  - Last beat is pos+N == TRB_WIDTH. On the last beat with no buf_valid: word_valid<=0, pos<=0.
- Backpressure:
  - While TRACE_READY_I=0, TRACE_O, pos and word_reg are held stable.
  - Prefetch may still fill buf.
- Latency:
  - First LOAD_O edge to TRACE_VALID_O=1 is 2 cycles (load to buf, then promote).
  - With LOAD_PERM_I held high and READY high, output is gapless across word boundaries.
- Simultaneous events:
  - Last-beat transfer, promotion and a new load in the same cycle are all legal.
  - buf is refilled with DATA_I while its old contents move to word_reg.
- Underrun:
  - If buf is empty at the last beat, TRACE_VALID_O drops for at least one cycle.
  - No partial or stale data is emitted.
- Reset mid-operation: partial word discarded; after release, the next loaded word restarts at bit 0.

Test Plan:
- EXP=0, one word 0x0000_0000_0000_00A5, READY=1 -> LOAD_O one pulse; after 2 cycles TRACE_O[0] = 1,0,1,0,0,1,0,1 then 56 zeros; VALID for exactly 64 cycles.
- EXP=3, LOAD_PERM held 1, words 0x0706050403020100 and 0x0F0E0D0C0B0A0908 -> 16 consecutive valid beats with TRACE_O = 0x00..0x0F; no VALID gap between beats 7 and 8; two LOAD_O pulses.
- EXP=2, READY low for 5 cycles at beat 3 -> TRACE_O and VALID stable all 5 cycles; beat 4 appears the cycle after READY rises; total 16 beats.
- LOAD_PERM drops after one word, EXP=3 -> VALID low after beat 8; LOAD_PERM rises at cycle t -> VALID high at t+2 with beat 0 of the new word.
- EXP switched 3->0 at beat 2 of a word -> remaining 6 beats stay 8-bit; next word is emitted as 64 single-bit beats.
- RST_I asserted between edges at beat 4 -> VALID and TRACE_O go to 0 without a clock edge, LOAD_O=0; after release the next word starts at bit 0.
